// File: rtl/eeg_pea_pkg.sv
// Shared definitions for the PE engine front end: FSM encodings, the
// activation RAM entry layout and the DIN beat presented to the PE.
package eeg_pea_pkg;

  // Widths shared with the PE datapath
  localparam int PEA_ACT_DW  = 8;   // activation data width
  localparam int PEA_WEI_DW  = 8;   // weight data width
  localparam int PEA_ADD_AW  = 10;  // activation address / RAM index width
  localparam int PEA_WEI_IW  = 3;   // tap index / kernel length width
  localparam int PEA_WEI_NUM = 7;   // max kernel taps held

  // Feeder FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One sparse activation RAM entry: {addr, data}
  typedef struct packed {
    logic [PEA_ADD_AW-1:0] addr;
    logic [PEA_ACT_DW-1:0] data;
  } act_entry_t;

  // One beat on the PE DIN interface
  typedef struct packed {
    logic                  act_lst;
    logic                  wei_lst;
    logic [PEA_ACT_DW-1:0] act_dat;
    logic [PEA_ADD_AW-1:0] act_add;
    logic [PEA_WEI_DW-1:0] wei_dat;
    logic [PEA_WEI_IW-1:0] wei_idx;
  } din_beat_t;

endpackage

// File: rtl/eeg_pea_feeder_buf.sv
// Two-entry first-word-fall-through buffer for activation RAM reads.
// It also tracks the single-cycle read in flight so the feeder only issues
// a read when occupancy plus in-flight reads stays within two entries.
module eeg_pea_feeder_buf
  import eeg_pea_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ren_p0,     // read issued to the RAM this cycle
  input  act_entry_t rdat_p1,    // RAM data, valid the cycle after ren_p0
  input  logic       pop,        // head consumed this cycle
  output logic       credit_ok,  // a new read may be issued this cycle
  output logic       head_vld,
  output act_entry_t head
);

  logic       vld_p1;
  logic [1:0] occ_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic       do_pop;
  logic [2:0] used_cnt;
  act_entry_t mem_q [2];

  assign head_vld = (occ_q != 2'd0);
  assign head     = mem_q[rd_ptr_q];
  assign do_pop   = pop && head_vld;

  // A pop in the same cycle returns its slot, so it counts toward credit
  assign used_cnt  = {1'b0, occ_q} + {2'b00, vld_p1} - {2'b00, do_pop};
  assign credit_ok = (used_cnt < 3'd2);

  // p0 -> p1: read request becomes returning data one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= ren_p0;
    end
  end

  // Pointer and occupancy bookkeeping for the two slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (vld_p1) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, vld_p1} - {1'b0, do_pop};
    end
  end

  // p1 -> buffer: capture returning RAM data into the write slot
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      mem_q[wr_ptr_q] <= rdat_p1;
    end
  end

endmodule

// File: rtl/eeg_pea_eng_feeder.sv
// PE engine feeder: walks the sparse activation RAM and the selected taps of
// one conv kernel, emitting one DIN beat per (activation, selected tap) pair.
// Taps 1..L-1 that are zero are skipped; tap 0 is always emitted so every
// activation produces at least one beat and the PE sees its framing.
module eeg_pea_eng_feeder
  import eeg_pea_pkg::*;
#(
  parameter int DATA_ACT_DW = PEA_ACT_DW,
  parameter int DATA_WEI_DW = PEA_WEI_DW,
  parameter int ARAM_ADD_AW = PEA_ADD_AW,
  parameter int CONV_WEI_DW = PEA_WEI_IW,
  parameter int WEI_NUM     = PEA_WEI_NUM
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            CFG_START,
  input  logic [ARAM_ADD_AW:0]            CFG_ACT_NUM,
  input  logic [CONV_WEI_DW-1:0]          CFG_CONV_WEI,
  input  logic [WEI_NUM*DATA_WEI_DW-1:0]  CFG_WEI_DAT,
  output logic                            IS_IDLE,
  output logic                            DONE,
  output logic                            ARAM_REN,
  output logic [ARAM_ADD_AW-1:0]          ARAM_RADD,
  input  logic [ARAM_ADD_AW+DATA_ACT_DW-1:0] ARAM_RDAT,
  output logic                            DIN_VLD,
  input  logic                            DIN_RDY,
  output logic                            ACT_LST,
  output logic                            WEI_LST,
  output logic [DATA_ACT_DW-1:0]          ACT_DAT,
  output logic [ARAM_ADD_AW-1:0]          ACT_ADD,
  output logic [DATA_WEI_DW-1:0]          WEI_DAT,
  output logic [CONV_WEI_DW-1:0]          WEI_IDX
);

  localparam logic [ARAM_ADD_AW:0] CNT_ONE = 1;

  // Tap k is selected when it is tap 0, or lies inside the kernel and is nonzero
  function automatic logic [WEI_NUM-1:0] calc_mask(
    input logic [CONV_WEI_DW-1:0]         len,
    input logic [WEI_NUM*DATA_WEI_DW-1:0] taps
  );
    logic [WEI_NUM-1:0] m;
    m = '0;
    for (int k = 0; k < WEI_NUM; k++) begin
      if (k == 0) begin
        m[k] = 1'b1;
      end else if ((k < int'(len)) && (taps[k*DATA_WEI_DW +: DATA_WEI_DW] != '0)) begin
        m[k] = 1'b1;
      end
    end
    return m;
  endfunction

  // Highest selected tap index; this is the beat that carries WEI_LST
  function automatic logic [CONV_WEI_DW-1:0] last_sel(input logic [WEI_NUM-1:0] m);
    logic [CONV_WEI_DW-1:0] r;
    r = '0;
    for (int k = 0; k < WEI_NUM; k++) begin
      if (m[k]) begin
        r = CONV_WEI_DW'(k);
      end
    end
    return r;
  endfunction

  // Smallest selected tap index strictly above the current one
  function automatic logic [CONV_WEI_DW-1:0] next_sel(
    input logic [WEI_NUM-1:0]     m,
    input logic [CONV_WEI_DW-1:0] cur
  );
    logic [CONV_WEI_DW-1:0] r;
    logic                   found;
    r     = cur;
    found = 1'b0;
    for (int k = 0; k < WEI_NUM; k++) begin
      if (!found && m[k] && (k > int'(cur))) begin
        r     = CONV_WEI_DW'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic [0:0]                     state_q;
  logic                           done_q;
  logic [ARAM_ADD_AW:0]           act_num_q;
  logic [ARAM_ADD_AW:0]           rd_cnt_q;
  logic [ARAM_ADD_AW:0]           ent_cnt_q;
  logic [WEI_NUM-1:0]             mask_q;
  logic [CONV_WEI_DW-1:0]         last_q;
  logic [CONV_WEI_DW-1:0]         tap_q;
  logic [WEI_NUM*DATA_WEI_DW-1:0] wei_q;

  logic       run;
  logic       start_go;
  logic       ren_p0;
  logic       credit_ok;
  logic       head_vld;
  logic       din_vld;
  logic       hs;
  logic       wei_lst;
  logic       act_lst;
  logic       pop;
  logic       job_end;
  act_entry_t rdat_p1;
  act_entry_t head;
  din_beat_t  beat;

  assign run      = (state_q == ST_RUN);
  assign start_go = CFG_START && (state_q == ST_IDLE);
  assign din_vld  = run && head_vld;
  assign wei_lst  = (tap_q == last_q);
  assign act_lst  = (ent_cnt_q == (act_num_q - CNT_ONE));
  assign hs       = din_vld && DIN_RDY;
  assign pop      = hs && wei_lst;
  assign job_end  = pop && act_lst;
  assign rdat_p1  = act_entry_t'(ARAM_RDAT);

  // p0: issue the next sequential read while credit and entries remain
  assign ren_p0 = run && credit_ok && (rd_cnt_q < act_num_q);

  eeg_pea_feeder_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ren_p0    (ren_p0),
    .rdat_p1   (rdat_p1),
    .pop       (pop),
    .credit_ok (credit_ok),
    .head_vld  (head_vld),
    .head      (head)
  );

  // Job FSM: an empty job completes from IDLE without entering RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (start_go && (CFG_ACT_NUM != '0)) begin
      state_q <= ST_RUN;
    end else if (job_end) begin
      state_q <= ST_IDLE;
    end
  end

  // DONE pulses the cycle after the job's final handshake (or an empty start)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (start_go && (CFG_ACT_NUM == '0)) || job_end;
    end
  end

  // Job configuration captured at start; the tap mask replaces the raw length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_num_q <= '0;
      mask_q    <= '0;
      last_q    <= '0;
    end else if (start_go) begin
      act_num_q <= CFG_ACT_NUM;
      mask_q    <= calc_mask(CFG_CONV_WEI, CFG_WEI_DAT);
      last_q    <= last_sel(calc_mask(CFG_CONV_WEI, CFG_WEI_DAT));
    end
  end

  // Tap values are pure data and only need to be valid while DIN_VLD is high
  always_ff @(posedge clk) begin
    if (start_go) begin
      wei_q <= CFG_WEI_DAT;
    end
  end

  // Read index, head entry index and tap pointer walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      ent_cnt_q <= '0;
      tap_q     <= '0;
    end else if (start_go) begin
      rd_cnt_q  <= '0;
      ent_cnt_q <= '0;
      tap_q     <= '0;
    end else begin
      if (ren_p0) begin
        rd_cnt_q <= rd_cnt_q + CNT_ONE;
      end
      if (hs) begin
        if (wei_lst) begin
          tap_q     <= '0;
          ent_cnt_q <= ent_cnt_q + CNT_ONE;
        end else begin
          tap_q <= next_sel(mask_q, tap_q);
        end
      end
    end
  end

  // Buffer head -> DIN beat; fields read as zero whenever no beat is offered
  always_comb begin
    beat = '0;
    if (din_vld) begin
      beat.act_lst = act_lst;
      beat.wei_lst = wei_lst;
      beat.act_dat = head.data;
      beat.act_add = head.addr;
      beat.wei_dat = wei_q[int'(tap_q)*DATA_WEI_DW +: DATA_WEI_DW];
      beat.wei_idx = tap_q;
    end
  end

  assign IS_IDLE   = (state_q == ST_IDLE);
  assign DONE      = done_q;
  assign ARAM_REN  = ren_p0;
  assign ARAM_RADD = rd_cnt_q[ARAM_ADD_AW-1:0];
  assign DIN_VLD   = din_vld;
  assign ACT_LST   = beat.act_lst;
  assign WEI_LST   = beat.wei_lst;
  assign ACT_DAT   = beat.act_dat;
  assign ACT_ADD   = beat.act_add;
  assign WEI_DAT   = beat.wei_dat;
  assign WEI_IDX   = beat.wei_idx;

endmodule

// File: tb/tb_eeg_pea_eng_feeder.sv
// Directed + randomized bench for eeg_pea_eng_feeder with a behavioural
// model of the expected beat stream and a simple RAM model.
module tb_eeg_pea_eng_feeder;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int IW = 3;
  localparam int WN = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              CFG_START;
  logic [AW:0]       CFG_ACT_NUM;
  logic [IW-1:0]     CFG_CONV_WEI;
  logic [WN*WW-1:0]  CFG_WEI_DAT;
  logic              IS_IDLE;
  logic              DONE;
  logic              ARAM_REN;
  logic [AW-1:0]     ARAM_RADD;
  logic [AW+DW-1:0]  ARAM_RDAT;
  logic              DIN_VLD;
  logic              DIN_RDY;
  logic              ACT_LST;
  logic              WEI_LST;
  logic [DW-1:0]     ACT_DAT;
  logic [AW-1:0]     ACT_ADD;
  logic [WW-1:0]     WEI_DAT;
  logic [IW-1:0]     WEI_IDX;

  logic [AW+DW-1:0]  ram [0:1023];
  logic [30:0]       exp_q [$];
  logic [30:0]       got_q [$];
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency
  always @(posedge clk) begin
    if (ARAM_REN) ARAM_RDAT <= ram[ARAM_RADD];
  end

  eeg_pea_eng_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CFG_START    (CFG_START),
    .CFG_ACT_NUM  (CFG_ACT_NUM),
    .CFG_CONV_WEI (CFG_CONV_WEI),
    .CFG_WEI_DAT  (CFG_WEI_DAT),
    .IS_IDLE      (IS_IDLE),
    .DONE         (DONE),
    .ARAM_REN     (ARAM_REN),
    .ARAM_RADD    (ARAM_RADD),
    .ARAM_RDAT    (ARAM_RDAT),
    .DIN_VLD      (DIN_VLD),
    .DIN_RDY      (DIN_RDY),
    .ACT_LST      (ACT_LST),
    .WEI_LST      (WEI_LST),
    .ACT_DAT      (ACT_DAT),
    .ACT_ADD      (ACT_ADD),
    .WEI_DAT      (WEI_DAT),
    .WEI_IDX      (WEI_IDX)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 1024; i++) ram[i] = (AW+DW)'($urandom);
  endtask

  function automatic logic [WN*WW-1:0] rand_taps();
    logic [WN*WW-1:0] t;
    for (int k = 0; k < WN; k++)
      t[k*WW +: WW] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return t;
  endfunction

  // Expected stream: every entry gets tap 0 plus each nonzero tap below L, ascending
  task automatic build_exp(input int n, input int len, input logic [WN*WW-1:0] taps);
    int  last;
    logic [WW-1:0] tv;
    exp_q.delete();
    last = 0;
    for (int k = 0; k < len; k++) begin
      tv = taps[k*WW +: WW];
      if (k == 0 || tv != 0) last = k;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < len; k++) begin
        tv = taps[k*WW +: WW];
        if (k == 0 || tv != 0)
          exp_q.push_back({(i == n-1), (k == last), ram[i][DW-1:0], ram[i][AW+DW-1:DW],
                           tv, IW'(k)});
      end
    end
  endtask

  // Runs one job from a posedge+#1 phase and returns at a posedge+#1 phase
  task automatic run_job(input int n, input int len, input logic [WN*WW-1:0] taps,
                         input bit rnd, input bit restart, input int abort_after);
    int hs_cnt, reads, pops, max_out, first_hs, last_hs, done_cnt, done_cyc, exp_radd, nchk;
    bit prev_stall, fin, aborted;
    logic [30:0] prev_beat, now_beat;
    hs_cnt = 0; reads = 0; pops = 0; max_out = 0; first_hs = -1; last_hs = -1;
    done_cnt = 0; done_cyc = -1; exp_radd = 0; prev_stall = 0; fin = 0; aborted = 0;
    prev_beat = '0;
    got_q.delete();
    build_exp(n, len, taps);
    CFG_ACT_NUM  = (AW+1)'(n);
    CFG_CONV_WEI = IW'(len);
    CFG_WEI_DAT  = taps;
    CFG_START    = 1'b1;
    DIN_RDY      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk); #1;
      now_beat = {ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX};
      if (c == 0) chk("ren_t0", ARAM_REN, 0);
      if (n > 0 && c == 1) begin
        chk("ren_t1", ARAM_REN, 1);
        chk("radd_t1", ARAM_RADD, 0);
      end
      if (n > 0 && c == 2) chk("vld_t2", DIN_VLD, 0);
      if (n > 0 && c == 3) chk("vld_t3", DIN_VLD, 1);
      if (n == 0 && c == 1) chk("done_t1", DONE, 1);
      if (prev_stall) chk("stall_hold", {DIN_VLD, now_beat}, {1'b1, prev_beat});
      if (ARAM_REN) begin
        chk("radd_seq", ARAM_RADD, exp_radd);
        exp_radd++;
        reads++;
      end
      if (DIN_VLD && DIN_RDY) begin
        got_q.push_back(now_beat);
        if (hs_cnt == 0) first_hs = c;
        last_hs = c;
        hs_cnt++;
        if (WEI_LST) pops++;
      end
      if (reads - pops > max_out) max_out = reads - pops;
      if (DONE) begin
        done_cnt++;
        done_cyc = c;
        chk("idle_at_done", IS_IDLE, 1);
        fin = 1;
      end
      prev_stall = DIN_VLD && !DIN_RDY;
      prev_beat  = now_beat;
      if (abort_after > 0 && hs_cnt >= abort_after) begin
        rst_n = 1'b0;
        #1;
        chk("abort_vld", DIN_VLD, 0);
        chk("abort_idle", IS_IDLE, 1);
        chk("abort_done", DONE, 0);
        repeat (2) begin
          @(negedge clk); #1;
          chk("abort_nodone", DONE, 0);
        end
        rst_n = 1'b1;
        repeat (2) begin
          @(negedge clk); #1;
          chk("post_abort_nodone", {DONE, DIN_VLD, IS_IDLE}, 3'b001);
        end
        aborted = 1;
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        CFG_START    = restart && (c == 3);
        CFG_ACT_NUM  = (AW+1)'($urandom_range(0, 2047));
        CFG_CONV_WEI = IW'($urandom_range(0, 7));
        CFG_WEI_DAT  = rand_taps();
        DIN_RDY      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    CFG_START = 1'b0;
    if (!aborted) begin
      chk("done_cnt", done_cnt, 1);
      chk("beat_cnt", got_q.size(), exp_q.size());
      nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nchk; i++) chk($sformatf("beat%0d", i), got_q[i], exp_q[i]);
      chk("reads", reads, n);
      chk("max_outstanding_le2", (max_out <= 2), 1);
      if (n > 0) chk("done_after_last", done_cyc, last_hs + 1);
      if (!rnd && n > 0) begin
        chk("first_beat_t3", first_hs, 3);
        chk("no_bubbles", last_hs - first_hs + 1, exp_q.size());
      end
      @(negedge clk); #1;
      chk("done_one_cycle", DONE, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [WN*WW-1:0] t;
    rst_n        = 1'b0;
    CFG_START    = 1'b0;
    CFG_ACT_NUM  = '0;
    CFG_CONV_WEI = '0;
    CFG_WEI_DAT  = '0;
    DIN_RDY      = 1'b0;
    fill_ram();
    #1;
    chk("rst_idle", IS_IDLE, 1);
    chk("rst_outs", {DONE, ARAM_REN, ARAM_RADD, DIN_VLD, ACT_LST, WEI_LST,
                     ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle_held", {IS_IDLE, DIN_VLD, ARAM_REN}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Kernel {5,0,7}, three activations
    run_job(3, 3, {8'h11, 8'h22, 8'h33, 8'h44, 8'h07, 8'h00, 8'h05}, 0, 0, 0);
    // Single-tap kernel, taps above L nonzero
    fill_ram();
    run_job(4, 1, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h03}, 0, 0, 0);
    // Fully sparse kernel of length 5
    run_job(5, 5, {8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0);
    // Same job with and without backpressure
    fill_ram();
    t = rand_taps();
    run_job(8, 4, t, 0, 0, 0);
    run_job(8, 4, t, 1, 0, 0);
    // Empty job
    run_job(0, 3, t, 0, 0, 0);
    // Start pulse while running must be ignored
    fill_ram();
    run_job(6, 3, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 0, 1, 0);
    // Reset after three beats, then a full job
    run_job(8, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h01}, 0, 0, 3);
    run_job(8, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h01}, 0, 0, 0);
    // Random jobs under random backpressure
    for (int j = 0; j < 4; j++) begin
      fill_ram();
      run_job($urandom_range(1, 12), $urandom_range(1, 7), rand_taps(), 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
